// File: rtl/axioma_alu_seq16.sv
// 16-bit word add/subtract sequencer: drives an external 8-bit ALU for the low byte, then the high byte,
// and registers the 16-bit result with SREG-style flags.
module axioma_alu_seq16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a_word,
    input  logic [15:0] b_word,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [15:0] result_word,
    output logic        flag_c,
    output logic        flag_z,
    output logic        flag_n,
    output logic        flag_v,
    output logic        flag_s,
    output logic [7:0]  alu_operand_a,
    output logic [7:0]  alu_operand_b,
    output logic [4:0]  alu_op,
    output logic        alu_flag_c_in,
    input  logic [7:0]  alu_result,
    input  logic        alu_flag_c_out,
    input  logic        alu_flag_v_out
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned OPC_W  = 5;
    localparam int unsigned IMM_W  = 6;

    localparam logic [OPC_W-1:0] ALU_ADD  = 5'b00000;
    localparam logic [OPC_W-1:0] ALU_ADC  = 5'b00001;
    localparam logic [OPC_W-1:0] ALU_SUB  = 5'b00010;
    localparam logic [OPC_W-1:0] ALU_SBC  = 5'b00011;
    localparam logic [OPC_W-1:0] ALU_PASS = 5'b11111;

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                sub_q, sub_d;
    logic [WORD_W-1:0]   a_q, a_d;
    logic [WORD_W-1:0]   b_q, b_d;
    logic [BYTE_W-1:0]   lo_q, lo_d;
    logic                carry_q, carry_d;
    logic [WORD_W-1:0]   result_q, result_d;
    logic                fc_q, fc_d, fz_q, fz_d, fn_q, fn_d, fv_q, fv_d, fs_q, fs_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Next-state, capture and ALU drive
    always_comb begin
        state_d       = state_q;
        sub_d         = sub_q;
        a_d           = a_q;
        b_d           = b_q;
        lo_d          = lo_q;
        carry_d       = carry_q;
        result_d      = result_q;
        fc_d          = fc_q;
        fz_d          = fz_q;
        fn_d          = fn_q;
        fv_d          = fv_q;
        fs_d          = fs_q;
        alu_op        = ALU_PASS;
        alu_operand_a = '0;
        alu_operand_b = '0;
        alu_flag_c_in = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sub_d   = op[0];
                    a_d     = a_word;
                    // Immediate forms only see the 6-bit constant
                    b_d     = op[1] ? b_word : WORD_W'(b_word[IMM_W-1:0]);
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                alu_operand_a = a_q[BYTE_W-1:0];
                alu_operand_b = b_q[BYTE_W-1:0];
                alu_op        = sub_q ? ALU_SUB : ALU_ADD;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    lo_d    = alu_result;
                    carry_d = alu_flag_c_out;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                alu_operand_a = a_q[WORD_W-1:BYTE_W];
                alu_operand_b = b_q[WORD_W-1:BYTE_W];
                alu_op        = sub_q ? ALU_SBC : ALU_ADC;
                alu_flag_c_in = carry_q;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = {alu_result, lo_q};
                    fc_d     = alu_flag_c_out;
                    fv_d     = alu_flag_v_out;
                    fz_d     = (result_d == '0);
                    fn_d     = alu_result[BYTE_W-1];
                    fs_d     = alu_result[BYTE_W-1] ^ alu_flag_v_out;
                    state_d  = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            sub_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            lo_q     <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            fc_q     <= 1'b0;
            fz_q     <= 1'b0;
            fn_q     <= 1'b0;
            fv_q     <= 1'b0;
            fs_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sub_q    <= sub_d;
            a_q      <= a_d;
            b_q      <= b_d;
            lo_q     <= lo_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            fc_q     <= fc_d;
            fz_q     <= fz_d;
            fn_q     <= fn_d;
            fv_q     <= fv_d;
            fs_q     <= fs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result_word = result_q;
    assign flag_c      = fc_q;
    assign flag_z      = fz_q;
    assign flag_n      = fn_q;
    assign flag_v      = fv_q;
    assign flag_s      = fs_q;

endmodule

// File: tb/tb_axioma_alu_seq16.sv
// Directed bench for axioma_alu_seq16 with a behavioural 8-bit ALU closing the loop.
module tb_axioma_alu_seq16;

    logic        clk, reset_n, start, abort;
    logic [1:0]  op;
    logic [15:0] a_word, b_word, result_word;
    logic        busy, done, flag_c, flag_z, flag_n, flag_v, flag_s;
    logic [7:0]  alu_operand_a, alu_operand_b, alu_result;
    logic [4:0]  alu_op;
    logic        alu_flag_c_in, alu_flag_c_out, alu_flag_v_out;
    logic [4:0]  flags;

    int n_checks = 0;
    int n_pass   = 0;
    logic [4:0] log_op [0:7];
    logic [7:0] log_a  [0:7];
    logic [7:0] log_b  [0:7];
    logic       log_busy1;

    assign flags = {flag_c, flag_z, flag_n, flag_v, flag_s};

    axioma_alu_seq16 dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .a_word(a_word), .b_word(b_word), .abort(abort),
        .busy(busy), .done(done), .result_word(result_word),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .flag_s(flag_s),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_op(alu_op), .alu_flag_c_in(alu_flag_c_in),
        .alu_result(alu_result), .alu_flag_c_out(alu_flag_c_out), .alu_flag_v_out(alu_flag_v_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 8-bit ALU (AVR-style: carry on subtract is the borrow)
    logic [8:0] t9;
    logic       is_add, is_sub;
    always_comb begin
        is_add = (alu_op == 5'b00000) || (alu_op == 5'b00001);
        is_sub = (alu_op == 5'b00010) || (alu_op == 5'b00011);
        case (alu_op)
            5'b00000: t9 = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
            5'b00001: t9 = {1'b0, alu_operand_a} + {1'b0, alu_operand_b} + {8'b0, alu_flag_c_in};
            5'b00010: t9 = {1'b0, alu_operand_a} - {1'b0, alu_operand_b};
            5'b00011: t9 = {1'b0, alu_operand_a} - {1'b0, alu_operand_b} - {8'b0, alu_flag_c_in};
            default:  t9 = {1'b0, alu_operand_a};
        endcase
        alu_result     = t9[7:0];
        alu_flag_c_out = (is_add || is_sub) ? t9[8] : 1'b0;
        if (is_add)
            alu_flag_v_out = (alu_operand_a[7] == alu_operand_b[7]) && (t9[7] != alu_operand_a[7]);
        else if (is_sub)
            alu_flag_v_out = (alu_operand_a[7] != alu_operand_b[7]) && (t9[7] != alu_operand_a[7]);
        else
            alu_flag_v_out = 1'b0;
    end

    // Issue one op and wait (bounded) for done; lat = negedges after acceptance until done
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a_word = a; b_word = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        log_busy1 = busy;
        log_op[1] = alu_op; log_a[1] = alu_operand_a; log_b[1] = alu_operand_b;
        while (done !== 1'b1 && lat < 7) begin
            @(negedge clk);
            lat++;
            log_op[lat] = alu_op; log_a[lat] = alu_operand_a; log_b[lat] = alu_operand_b;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b1; abort = 1'b0; op = 2'b10; a_word = 16'h1111; b_word = 16'h2222;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_checks++; if (result_word !== 16'h0000) $display("FAIL reset_result got %h want 0000", result_word); else n_pass++;
        n_checks++; if (flags !== 5'b00000) $display("FAIL reset_flags got %b want 00000", flags); else n_pass++;
        n_checks++; if (alu_op !== 5'b11111 || alu_operand_a !== 8'h00 || alu_operand_b !== 8'h00 || alu_flag_c_in !== 1'b0)
            $display("FAIL reset_alu_idle got op %b a %h b %h cin %b want 11111 00 00 0", alu_op, alu_operand_a, alu_operand_b, alu_flag_c_in);
        else n_pass++;
        start = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_adiw();
        int lat;
        run_op(2'b00, 16'h00FF, 16'h0001, lat);
        n_checks++; if (log_busy1 !== 1'b1) $display("FAIL adiw_busy got %b want 1", log_busy1); else n_pass++;
        n_checks++; if (lat !== 3) $display("FAIL adiw_latency got %0d want 3", lat); else n_pass++;
        n_checks++; if (result_word !== 16'h0100) $display("FAIL adiw_result got %h want 0100", result_word); else n_pass++;
        n_checks++; if (flags !== 5'b00000) $display("FAIL adiw_flags got %b want 00000", flags); else n_pass++;
        n_checks++; if (log_op[3] !== 5'b11111 || log_a[3] !== 8'h00 || log_b[3] !== 8'h00)
            $display("FAIL done_alu_pass got op %b a %h b %h want 11111 00 00", log_op[3], log_a[3], log_b[3]);
        else n_pass++;
    endtask

    task automatic test_sbiw();
        int lat;
        run_op(2'b01, 16'h0000, 16'h0001, lat);
        n_checks++; if (lat !== 3) $display("FAIL sbiw_latency got %0d want 3", lat); else n_pass++;
        n_checks++; if (result_word !== 16'hFFFF) $display("FAIL sbiw_result got %h want ffff", result_word); else n_pass++;
        n_checks++; if (flags !== 5'b10101) $display("FAIL sbiw_flags got %b want 10101", flags); else n_pass++;
    endtask

    task automatic test_add16_sub16();
        int lat;
        run_op(2'b10, 16'h7FFF, 16'h0001, lat);
        n_checks++; if (result_word !== 16'h8000) $display("FAIL add16_result got %h want 8000", result_word); else n_pass++;
        n_checks++; if (flags !== 5'b00110) $display("FAIL add16_flags got %b want 00110", flags); else n_pass++;
        run_op(2'b11, 16'h1234, 16'h1234, lat);
        n_checks++; if (result_word !== 16'h0000) $display("FAIL sub16_result got %h want 0000", result_word); else n_pass++;
        n_checks++; if (flags !== 5'b01000) $display("FAIL sub16_flags got %b want 01000", flags); else n_pass++;
        n_checks++; if (log_op[1] !== 5'b00010 || log_op[2] !== 5'b00011)
            $display("FAIL sub16_alu_ops got %b %b want 00010 00011", log_op[1], log_op[2]);
        else n_pass++;
    endtask

    task automatic test_imm_mask();
        int lat;
        run_op(2'b00, 16'h1000, 16'hFFC5, lat);
        n_checks++; if (result_word !== 16'h1005) $display("FAIL mask_result got %h want 1005", result_word); else n_pass++;
        n_checks++; if (log_op[1] !== 5'b00000 || log_op[2] !== 5'b00001)
            $display("FAIL mask_alu_ops got %b %b want 00000 00001", log_op[1], log_op[2]);
        else n_pass++;
        n_checks++; if (log_b[1] !== 8'h05 || log_b[2] !== 8'h00)
            $display("FAIL mask_operand_b got %h %h want 05 00", log_b[1], log_b[2]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        int last_k = -1;
        int bad_gap = 0;
        logic [15:0] first_res = 16'h0;
        logic [15:0] second_res = 16'h0;
        @(negedge clk);
        start = 1'b1; op = 2'b10; a_word = 16'h0100; b_word = 16'h0023;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin a_word = 16'hFFFF; b_word = 16'hFFFF; end
            if (done === 1'b1) begin
                if (dones == 0) first_res = result_word;
                else if (k - last_k != 4) bad_gap++;
                if (dones == 1) second_res = result_word;
                dones++;
                last_k = k;
            end
            if (k == 11) start = 1'b0;
        end
        n_checks++; if (dones !== 3) $display("FAIL b2b_done_count got %0d want 3", dones); else n_pass++;
        n_checks++; if (bad_gap !== 0) $display("FAIL b2b_done_spacing got %0d bad gaps want 0", bad_gap); else n_pass++;
        n_checks++; if (first_res !== 16'h0123) $display("FAIL b2b_first_result got %h want 0123", first_res); else n_pass++;
        n_checks++; if (second_res !== 16'hFFFE) $display("FAIL b2b_second_result got %h want fffe", second_res); else n_pass++;
    endtask

    task automatic test_abort();
        int lat;
        int seen = 0;
        run_op(2'b10, 16'h0001, 16'h0001, lat);
        @(negedge clk);
        start = 1'b1; op = 2'b11; a_word = 16'h0005; b_word = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (result_word !== 16'h0002) $display("FAIL abort_result_held got %h want 0002", result_word); else n_pass++;
        n_checks++; if (flags !== 5'b00000) $display("FAIL abort_flags_held got %b want 00000", flags); else n_pass++;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL abort_no_done got %0d pulses want 0", seen); else n_pass++;
        // Abort while idle must not block a start
        start = 1'b1; abort = 1'b1; op = 2'b10; a_word = 16'h0010; b_word = 16'h0020;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL idle_abort_busy got %b want 1", busy); else n_pass++;
        lat = 1;
        while (done !== 1'b1 && lat < 7) begin @(negedge clk); lat++; end
        n_checks++; if (result_word !== 16'h0030 || lat !== 3)
            $display("FAIL idle_abort_result got %h lat %0d want 0030 lat 3", result_word, lat);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a_word = 16'h1234; b_word = 16'h0001;
        @(negedge clk);
        start = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midreset_busy_done got %b%b want 00", busy, done); else n_pass++;
        n_checks++; if (result_word !== 16'h0000) $display("FAIL midreset_result got %h want 0000", result_word); else n_pass++;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL midreset_no_done got %0d pulses want 0", seen); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_adiw();
        test_sbiw();
        test_add16_sub16();
        test_imm_mask();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axioma_alu_seq16.md
AXIOMA_ALU_SEQ16 -- requirements
Module: axioma_alu_seq16

Interface
REQ-001 SHALL have parameter none; all widths fixed: word 16 bits, ALU byte 8 bits, ALU opcode 5 bits.
REQ-002 SHALL use a single clock and a synchronous, active-low reset; ports as listed below (clock and reset first).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  request; accepted only when busy=0.
REQ-006 op  input  2  00=ADIW, 01=SBIW, 10=ADD16, 11=SUB16.
REQ-007 a_word  input  16  first operand (register pair).
REQ-008 b_word  input  16  second operand; ADIW/SBIW use b_word[5:0] zero-extended.
REQ-009 abort  input  1  synchronous cancel of an in-flight operation.
REQ-010 busy  output  1  high from the cycle after acceptance through the DONE cycle.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 result_word  output  16  final 16-bit result.
REQ-013 flag_c/flag_z/flag_n/flag_v/flag_s  output  1 each  16-bit SREG flags.
REQ-014 alu_operand_a, alu_operand_b  output  8 each  operand bytes driven to the 8-bit ALU.
REQ-015 alu_op  output  5  ALU opcode (ADD=00000, ADC=00001, SUB=00010, SBC=00011, PASS=11111).
REQ-016 alu_flag_c_in  output  1  carry input to the ALU.
REQ-017 alu_result  input  8  ALU result byte (combinational from driven operands).
REQ-018 alu_flag_c_out, alu_flag_v_out  input  1 each  ALU carry and overflow.

Function
REQ-019 SHALL implement FSM states IDLE, LOW, HIGH, DONE.
REQ-020 IDLE: start=1 -> capture op, a_word, b_word (masked to [5:0] for op 00/01) and go to LOW; otherwise stay.
REQ-021 LOW: drive low bytes, alu_op=ADD (op 00/10) or SUB (op 01/11), alu_flag_c_in=0; register alu_result as low byte and alu_flag_c_out as internal carry; go to HIGH.
REQ-022 HIGH: drive high bytes, alu_op=ADC or SBC, alu_flag_c_in=registered carry; register alu_result as high byte, alu_flag_c_out, alu_flag_v_out; go to DONE.
REQ-023 DONE: done=1 for exactly this cycle; result_word and all flags valid; go to IDLE unconditionally.
REQ-024 Latency: done asserted in the 3rd cycle after the acceptance edge; a new start may be accepted on the cycle after DONE (throughput one op per 4 cycles).
REQ-025 start while busy=1 (LOW/HIGH/DONE) SHALL be ignored; no queuing.
REQ-026 Flags at DONE: C=high-byte ALU carry; Z=(result_word==0), computed over all 16 bits; N=result_word[15]; V=high-byte ALU V; S=N^V.
REQ-027 In IDLE and DONE, ALU outputs SHALL be alu_op=PASS, operands 0x00, alu_flag_c_in=0.
REQ-028 result_word and flags SHALL update only on DONE entry and hold until the next completion.
REQ-029 abort=1 in LOW or HIGH SHALL return to IDLE next cycle, no done pulse, result_word/flags unchanged; abort in IDLE/DONE has no effect; abort takes priority over start in the same cycle.

Reset
REQ-030 reset_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, result_word=0x0000, all flags 0, internal carry 0, captured operands 0.
REQ-031 Reset mid-operation SHALL discard the operation with no done pulse; reset has priority over start and abort.

Verification
REQ-032 ADIW a=0x00FF, b=0x0001 -> done at cycle 3, result 0x0100, C0 Z0 N0 V0 S0.
REQ-033 SBIW a=0x0000, b=0x0001 -> result 0xFFFF, C1 Z0 N1 V0 S1.
REQ-034 ADD16 a=0x7FFF, b=0x0001 -> result 0x8000, C0 Z0 N1 V1 S0; SUB16 a=0x1234, b=0x1234 -> 0x0000, Z1 C0 N0 V0.
REQ-035 ADIW a=0x1000, b=0xFFC5 -> only 0x05 added, result 0x1005; ALU sees alu_op 00000 then 00001.
REQ-036 start pulsed in every cycle of an op -> exactly one done per 4 cycles, captured operands unchanged mid-op.
REQ-037 abort in HIGH, and separately reset_n=0 in LOW -> no done, busy low next cycle, result_word retains prior value (abort) or 0x0000 (reset).
